prog_ctr: RTL

Program counter and fetch sequencer for the single-cycle core. It drives the 5-bit pointer into the branch-target LUT and consumes the 12-bit `Target` it returns. It owns the start/halt handshake with the testbench and the per-run instruction count. Its `ProgCtr` output addresses instruction ROM directly.

---
 rtl/prog_ctr_pkg.sv | 24 ++
 rtl/sat_ctr.sv | 25 ++
 rtl/prog_ctr.sv | 115 +++++++++++
 3 files changed

// File: rtl/prog_ctr_pkg.sv
// Shared types and width defaults for the program counter / fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_ctr_pkg;

  localparam int PC_W_DEF  = 12;
  localparam int SEL_W_DEF = 5;
  localparam int OFF_W_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    NPC_HOLD = 2'd0,
    NPC_INC  = 2'd1,
    NPC_ABS  = 2'd2,
    NPC_REL  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/sat_ctr.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Latency: count reflects clr/en one cycle after the sampling edge.
// Backpressure: none; en simply gates counting.
module sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count up on enable, stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE run control, next-PC mux, retired count.
// Latency: one cycle per instruction; ProgCtr/Running/Done update on the edge sampling inputs.
// Backpressure: Stall freezes PC, state and counter for the cycle; Start only honoured in IDLE/DONE.
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             RelEn,
  input  logic             Taken,
  input  logic [SEL_W-1:0] BranchSel,
  input  logic [OFF_W-1:0] Offset,
  input  logic [PC_W-1:0]  Target,
  output logic [SEL_W-1:0] LutAddr,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  pc_state_t       state, state_nxt;
  npc_sel_t        npc_sel;
  logic            load;
  logic            cnt_clr;
  logic            cnt_en;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] off_ext;

  // The LUT lookup is purely combinational so a taken branch resolves in one cycle.
  assign LutAddr = BranchSel;
  assign off_ext = {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset};

  // Run-control and next-PC selection; Stall masks everything in RUN, Halt has top priority.
  always_comb begin
    state_nxt = state;
    npc_sel   = NPC_HOLD;
    load      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = RUN;
          load      = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (!Stall) begin
          cnt_en = 1'b1;
          if (Halt) begin
            state_nxt = DONE;
          end else if (BranchEn && Taken) begin
            npc_sel = NPC_ABS;
          end else if (RelEn && Taken) begin
            npc_sel = NPC_REL;
          end else begin
            npc_sel = NPC_INC;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next-PC mux; arithmetic wraps naturally at PC_W bits.
  always_comb begin
    pc_nxt = ProgCtr;
    if (load) begin
      pc_nxt = StartAddr;
    end else begin
      case (npc_sel)
        NPC_INC:  pc_nxt = ProgCtr + 1'b1;
        NPC_ABS:  pc_nxt = Target;
        NPC_REL:  pc_nxt = ProgCtr + off_ext;
        default:  pc_nxt = ProgCtr;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      ProgCtr <= '0;
    end else begin
      state   <= state_nxt;
      ProgCtr <= pc_nxt;
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == DONE);

  sat_ctr #(
    .W (CNT_W)
  ) u_inst_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (InstCount)
  );

endmodule
